// File: rtl/spi_slave_bridge_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared types and constants for the SPI slave bridge: FSM state encoding,
// the command field values carried in rx_data[9:8], and the default frame
// geometry.
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int FRAME_W    = DEF_DATA_W + 2;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } spi_state_e;

endpackage

// File: rtl/spi_slave_bridge_if.sv
// -----------------------------------------------------------------------------
// spi_slave_bridge_if
// Bundles the serial pins and the RAM-side frame/response signals.
//   SS_n, MOSI, MISO      : SPI pins (clk is the bit clock, kept outside)
//   rx_data, rx_valid     : received frame towards the RAM
//   tx_data, tx_valid     : read data coming back from the RAM
// Modport slave is the bridge's view; master is the view of the
// environment (SPI master pins plus RAM).
// -----------------------------------------------------------------------------
interface spi_slave_bridge_if #(
  parameter int DATA_W = spi_pkg::DEF_DATA_W
);

  logic              SS_n;
  logic              MOSI;
  logic              MISO;
  logic [DATA_W+1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;

  modport slave (
    input  SS_n,
    input  MOSI,
    output MISO,
    output rx_data,
    output rx_valid,
    input  tx_data,
    input  tx_valid
  );

  modport master (
    output SS_n,
    output MOSI,
    input  MISO,
    input  rx_data,
    input  rx_valid,
    output tx_data,
    output tx_valid
  );

endinterface

// File: rtl/spi_slave_bridge_tx_shifter.sv
// -----------------------------------------------------------------------------
// spi_tx_shifter
// Parallel-to-serial stage for read data. On load the MSB appears on miso at
// once; the remaining bits follow one per cycle, then miso returns to 0 and
// done is raised until the slave select is released.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   ss_n     : slave select (high clears everything)
//   load     : capture din and start shifting
//   din      : word to send, MSB first
//   miso     : registered serial output
//   busy     : a word is being shifted out
//   done     : the whole word has been shifted out
// -----------------------------------------------------------------------------
module spi_tx_shifter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss_n,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  output logic              miso,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     cnt;

  always_ff @(posedge clk) begin
    if (rst || ss_n) begin
      shreg <= '0;
      cnt   <= '0;
      miso  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (load) begin
      // MSB goes out straight away; cnt counts the bits still to follow.
      miso  <= din[DATA_W-1];
      shreg <= {din[DATA_W-2:0], 1'b0};
      cnt   <= CW'(DATA_W - 1);
      busy  <= 1'b1;
      done  <= 1'b0;
    end else if (busy) begin
      if (cnt == '0) begin
        miso <= 1'b0;
        busy <= 1'b0;
        done <= 1'b1;
      end else begin
        miso  <= shreg[DATA_W-1];
        shreg <= {shreg[DATA_W-2:0], 1'b0};
        cnt   <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_slave_bridge.sv
// -----------------------------------------------------------------------------
// spi_slave_bridge
// SPI slave front end for the single-port RAM. After SS_n falls, one command
// bit chooses write or read; a 10-bit frame is then shifted in MSB first and
// presented to the RAM with a one-cycle rx_valid. A read-address frame arms
// addr_held so the next read frame is treated as read-data; the read-data
// frame waits for the RAM's tx_valid and serialises tx_data onto MISO.
// Ports:
//   clk  : clock, also the SPI bit clock
//   rst  : synchronous active-high reset
//   bus  : spi_slave_bridge_if.slave (SS_n, MOSI, MISO, rx_data, rx_valid,
//          tx_data, tx_valid)
// -----------------------------------------------------------------------------
module spi_slave_bridge
  import spi_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input logic              clk,
  input logic              rst,
  spi_slave_bridge_if.slave bus
);

  localparam int FW = DATA_W + 2;
  localparam int CW = $clog2(FW);

  spi_state_e    state;
  logic [CW-1:0] bit_cnt;
  logic          rx_done;
  logic          addr_held;
  logic          tx_load;
  logic          tx_busy;
  logic          tx_done;

  // The RAM response window opens once the read-data frame has been sent and
  // closes as soon as one word has been accepted.
  assign tx_load = (state == READ_DATA) && rx_done && !tx_busy && !tx_done &&
                   !bus.SS_n && bus.tx_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      rx_done   <= 1'b0;
      addr_held <= 1'b0;
      bus.rx_data  <= '0;
      bus.rx_valid <= 1'b0;
    end else begin
      bus.rx_valid <= 1'b0;
      if (bus.SS_n) begin
        // Deselect aborts any partial frame; addr_held survives on purpose.
        state   <= IDLE;
        bit_cnt <= '0;
        rx_done <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= CHK_CMD;
          CHK_CMD: begin
            bit_cnt <= '0;
            rx_done <= 1'b0;
            if (!bus.MOSI)      state <= WRITE;
            else if (addr_held) state <= READ_DATA;
            else                state <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            // Once the frame is complete MOSI is ignored until deselect.
            if (!rx_done) begin
              bus.rx_data <= {bus.rx_data[FW-2:0], bus.MOSI};
              if (bit_cnt == CW'(FW - 1)) begin
                bus.rx_valid <= 1'b1;
                rx_done      <= 1'b1;
                bit_cnt      <= '0;
                if (state == READ_ADD)  addr_held <= 1'b1;
                if (state == READ_DATA) addr_held <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  spi_tx_shifter #(
    .DATA_W (DATA_W)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .ss_n (bus.SS_n),
    .load (tx_load),
    .din  (bus.tx_data),
    .miso (bus.MISO),
    .busy (tx_busy),
    .done (tx_done)
  );

endmodule

// File: tb/tb_spi_slave_bridge.sv
module tb_spi_slave_bridge;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   held_m;

  spi_slave_bridge_if #(.DATA_W(8)) bus ();

  spi_slave_bridge #(.DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Random tx_valid noise; only used where the bridge must ignore it.
  task automatic spur();
    bus.tx_valid = 1'($urandom_range(0, 1));
    bus.tx_data  = 8'($urandom);
  endtask

  // One SS_n-low transaction. Reference behaviour:
  //   cmd 0 -> write; cmd 1 -> read-address if no address held, else read-data.
  //   ab   : edges with SS_n low before deselect (>=12 means full frame).
  //   txdly: idle cycles after rx_valid before the RAM answers (read-data).
  //   mab  : MISO bit index at which SS_n is raised (>=10 means never).
  task automatic do_frame(input bit cmd, input logic [FRAME_W-1:0] fr, input int ab,
                          input logic [7:0] txd, input int txdly, input int mab);
    int   br;
    bit   aborted;
    logic exp_bit;
    br = (cmd == 1'b0) ? 0 : (held_m ? 2 : 1);
    aborted = 1'b0;

    bus.SS_n = 1'b0; bus.MOSI = 1'($urandom); spur(); step();
    chk("rx_valid_start", 32'(bus.rx_valid), 32'd0);
    if (ab == 1) aborted = 1'b1;
    else begin
      bus.MOSI = cmd; spur(); step();
      for (int i = 0; i < 10; i++) begin
        if (ab == 2 + i) begin aborted = 1'b1; break; end
        bus.MOSI = fr[9-i]; spur(); step();
        chk("rx_valid_shift", 32'(bus.rx_valid), 32'(i == 9));
      end
    end

    if (!aborted) begin
      chk("rx_data", 32'(bus.rx_data), 32'(fr));
      if (br == 1) held_m = 1'b1;
      if (br == 2) held_m = 1'b0;
      chk("addr_held_frame", 32'(dut.addr_held), 32'(held_m));
      if (br == 2) begin
        for (int j = 0; j < txdly; j++) begin
          bus.tx_valid = 1'b0; bus.MOSI = 1'($urandom); step();
          chk("miso_wait", 32'(bus.MISO), 32'd0);
          chk("rx_valid_pulse", 32'(bus.rx_valid), 32'd0);
        end
        bus.tx_valid = 1'b1; bus.tx_data = txd; step();
        chk("miso_bit7", 32'(bus.MISO), 32'(txd[7]));
        for (int b = 1; b < 10; b++) begin
          if (b == mab) break;
          exp_bit = (b < 8) ? txd[7-b] : 1'b0;
          spur(); bus.MOSI = 1'($urandom); step();
          chk("miso_bit", 32'(bus.MISO), 32'(exp_bit));
        end
      end else begin
        for (int j = 0; j < 3; j++) begin
          spur(); bus.MOSI = 1'($urandom); step();
          chk("miso_quiet", 32'(bus.MISO), 32'd0);
          chk("rx_valid_pulse", 32'(bus.rx_valid), 32'd0);
          chk("rx_data_hold", 32'(bus.rx_data), 32'(fr));
        end
      end
    end

    bus.SS_n = 1'b1; spur(); step();
    chk("state_idle", 32'(dut.state), 32'(IDLE));
    chk("miso_idle", 32'(bus.MISO), 32'd0);
    chk("rx_valid_idle", 32'(bus.rx_valid), 32'd0);
    chk("addr_held", 32'(dut.addr_held), 32'(held_m));
    bus.tx_valid = 1'b0;
  endtask

  initial begin
    logic [FRAME_W-1:0] fr;
    rst = 1'b1; bus.SS_n = 1'b1; bus.MOSI = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = '0;
    held_m = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    chk("rst_rx_data", 32'(bus.rx_data), 32'd0);
    chk("rst_miso", 32'(bus.MISO), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    chk("rst_addr_held", 32'(dut.addr_held), 32'd0);

    // Directed write / read sequence.
    do_frame(1'b0, {CMD_WR_ADDR, 8'hA5}, 99, 8'h00, 0, 99);
    do_frame(1'b0, {CMD_WR_DATA, 8'h3C}, 99, 8'h00, 0, 99);
    do_frame(1'b1, {CMD_RD_ADDR, 8'hA5}, 99, 8'h00, 0, 99);
    do_frame(1'b1, {CMD_RD_DATA, 8'h00}, 99, 8'hC3, 1, 99);
    do_frame(1'b1, {CMD_RD_ADDR, 8'h11}, 99, 8'h00, 0, 99);
    do_frame(1'b1, {CMD_RD_DATA, 8'h00}, 99, 8'h5A, 0, 99);

    // Abort after 5 frame bits, then a clean frame.
    do_frame(1'b0, {CMD_WR_ADDR, 8'hFF}, 7, 8'h00, 0, 99);
    do_frame(1'b0, {CMD_WR_DATA, 8'h55}, 99, 8'h00, 0, 99);

    // Spurious RAM response while idle.
    bus.tx_valid = 1'b1; bus.tx_data = 8'hFF; step();
    chk("spur_idle_miso", 32'(bus.MISO), 32'd0);
    bus.tx_valid = 1'b0;

    // Reset in the middle of a frame with an address held.
    do_frame(1'b1, {CMD_RD_ADDR, 8'h42}, 99, 8'h00, 0, 99);
    bus.SS_n = 1'b0; step();
    bus.MOSI = 1'b1; step();
    for (int i = 0; i < 4; i++) begin bus.MOSI = 1'($urandom); step(); end
    rst = 1'b1; step(); step();
    held_m = 1'b0;
    chk("midrst_rx_valid", 32'(bus.rx_valid), 32'd0);
    chk("midrst_miso", 32'(bus.MISO), 32'd0);
    chk("midrst_state", 32'(dut.state), 32'(IDLE));
    chk("midrst_addr_held", 32'(dut.addr_held), 32'd0);
    rst = 1'b0; bus.SS_n = 1'b1; step();

    // Randomised frames with deselects anywhere.
    for (int n = 0; n < 1000; n++) begin
      int ab, mab, gap;
      fr  = FRAME_W'($urandom);
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 11)) : 99;
      mab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : 99;
      do_frame(1'($urandom), fr, ab, 8'($urandom), int'($urandom_range(0, 3)), mab);
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        spur(); step();
        chk("gap_miso", 32'(bus.MISO), 32'd0);
      end
      bus.tx_valid = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
